main_mem_ctrl: RTL and testbench

Sequencing controller and two-port arbiter in front of the single-port, fixed-latency main memory. It accepts read requests from the instruction-fetch port (I) and read/write requests from the load/store port (D). One request is granted at a time. For each granted request the block holds the memory's chip-select, read/write strobes, address and tri-state data bus for the configured latency, then returns the read data or write acknowledgement to the requester. It sits between the fetch unit/LSU and the main memory instance.

---
 rtl/main_mem_ctrl_pkg.sv | 28 ++
 rtl/mem_arb2.sv | 51 +++++
 rtl/main_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_main_mem_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_ctrl_pkg.sv
// Shared types for the main-memory controller: FSM states, request sources and counter sizing.
// Optional build macro ROUND_ROBIN_EN (see mem_arb2) does not change anything here.
package main_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } src_e;

   // Bit positions of each requester in the arbiter req/gnt vectors
   localparam int GNT_I = 0;
   localparam int GNT_D = 1;

   // The counter holds at most LATENCY-1, so clog2 of the larger latency is enough (min 1 bit)
   function automatic int cnt_width(input int rd_lat, input int wr_lat);
      int m;
      m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/mem_arb2.sv
// Two-requester arbiter, one-hot grant. Fixed D-over-I priority by default;
// with ROUND_ROBIN_EN defined a last-grant pointer breaks ties in favour of the port not granted last.
module mem_arb2
   import main_mem_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

`ifdef ROUND_ROBIN_EN
   logic last_d_q, last_d_d;

   always_comb begin
      gnt      = 2'b00;
      last_d_d = last_d_q;
      if (req[GNT_D] && (!req[GNT_I] || !last_d_q)) begin
         gnt[GNT_D] = 1'b1;
      end else if (req[GNT_I]) begin
         gnt[GNT_I] = 1'b1;
      end
      if (accept) begin
         last_d_d = gnt[GNT_D];
      end
   end

   // Reset value 0 means "I granted last", so the first tie goes to D
   always_ff @(posedge clk) begin
      if (rst) begin
         last_d_q <= 1'b0;
      end else begin
         last_d_q <= last_d_d;
      end
   end
`else
   logic unused_ok;
   assign unused_ok = ^{clk, rst, accept};

   always_comb begin
      gnt = 2'b00;
      if (req[GNT_D]) begin
         gnt[GNT_D] = 1'b1;
      end else if (req[GNT_I]) begin
         gnt[GNT_I] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/main_mem_ctrl.sv
// Sequencer/arbiter in front of a single-port fixed-latency memory: one I/D request at a time.
// Build macro ROUND_ROBIN_EN selects round-robin tie breaking in mem_arb2.
module main_mem_ctrl
   import main_mem_ctrl_pkg::*;
#(
   parameter int READ_LATENCY  = 10,
   parameter int WRITE_LATENCY = 10,
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 20
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   output logic                  i_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   output logic                  i_resp_valid,
   output logic [DATA_WIDTH-1:0] i_resp_data,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic                  d_req_we,
   input  logic [ADDR_WIDTH-1:0] d_req_addr,
   input  logic [DATA_WIDTH-1:0] d_req_wdata,
   output logic                  d_resp_valid,
   output logic [DATA_WIDTH-1:0] d_resp_rdata,
   output logic                  mem_cs,
   output logic                  mem_re,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [DATA_WIDTH-1:0] mem_data
);

   localparam int CNT_W = cnt_width(READ_LATENCY, WRITE_LATENCY);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   src_e                  src_q, src_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

   logic [1:0] req, gnt;
   logic       accept;

   // Requests are only visible to the arbiter in IDLE and outside reset
   assign req[GNT_I] = i_req_valid && (state_q == ST_IDLE) && !rst;
   assign req[GNT_D] = d_req_valid && (state_q == ST_IDLE) && !rst;
   assign accept     = |gnt;

   mem_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .accept (accept),
      .gnt    (gnt)
   );

   assign i_req_ready  = gnt[GNT_I];
   assign d_req_ready  = gnt[GNT_D];
   assign i_resp_data  = i_rdata_q;
   assign d_resp_rdata = d_rdata_q;
   assign mem_addr     = addr_q;
   assign mem_data     = (state_q == ST_WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      src_d        = src_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      mem_cs       = 1'b0;
      mem_re       = 1'b0;
      mem_wr       = 1'b0;
      i_resp_valid = 1'b0;
      d_resp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               src_d   = gnt[GNT_D] ? SRC_D : SRC_I;
               we_d    = gnt[GNT_D] && d_req_we;
               addr_d  = gnt[GNT_D] ? d_req_addr : i_req_addr;
               wdata_d = d_req_wdata;
               if (we_d) begin
                  cnt_d   = WR_LOAD;
                  state_d = ST_WRITE;
               end else begin
                  cnt_d   = RD_LOAD;
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            mem_cs = 1'b1;
            mem_re = 1'b1;
            if (cnt_q == '0) begin
               if (src_q == SRC_D) begin
                  d_rdata_d = mem_data;
               end else begin
                  i_rdata_d = mem_data;
               end
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WRITE: begin
            mem_cs = 1'b1;
            mem_wr = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            i_resp_valid = (src_q == SRC_I);
            d_resp_valid = (src_q == SRC_D);
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         src_q     <= SRC_I;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         src_q     <= src_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: directed vector table, tie/reset sequences, a
// short-latency instance, and random traffic against a transaction-level model (ROUND_ROBIN_EN aware).
module tb_main_mem_ctrl;

   localparam int RL = 10, WL = 10, RL2 = 2, WL2 = 1, AW = 20, DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          i_req_valid = 1'b0, i_req_ready, i_resp_valid;
   logic [AW-1:0] i_req_addr = '0;
   logic [DW-1:0] i_resp_data;
   logic          d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0, d_resp_valid;
   logic [AW-1:0] d_req_addr = '0;
   logic [DW-1:0] d_req_wdata = '0, d_resp_rdata;
   logic          mem_cs, mem_re, mem_wr;
   logic [AW-1:0] mem_addr;
   wire  [DW-1:0] mem_data;

   logic          i_req_valid2 = 1'b0, i_req_ready2, i_resp_valid2;
   logic [AW-1:0] i_req_addr2 = '0;
   logic [DW-1:0] i_resp_data2;
   logic          d_req_valid2 = 1'b0, d_req_ready2, d_req_we2 = 1'b0, d_resp_valid2;
   logic [AW-1:0] d_req_addr2 = '0;
   logic [DW-1:0] d_req_wdata2 = '0, d_resp_rdata2;
   logic          mem_cs2, mem_re2, mem_wr2;
   logic [AW-1:0] mem_addr2;
   wire  [DW-1:0] mem_data2;

   main_mem_ctrl #(.READ_LATENCY(RL), .WRITE_LATENCY(WL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
      .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
      .mem_cs(mem_cs), .mem_re(mem_re), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data));

   main_mem_ctrl #(.READ_LATENCY(RL2), .WRITE_LATENCY(WL2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut2 (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid2), .i_req_ready(i_req_ready2), .i_req_addr(i_req_addr2),
      .i_resp_valid(i_resp_valid2), .i_resp_data(i_resp_data2),
      .d_req_valid(d_req_valid2), .d_req_ready(d_req_ready2), .d_req_we(d_req_we2),
      .d_req_addr(d_req_addr2), .d_req_wdata(d_req_wdata2),
      .d_resp_valid(d_resp_valid2), .d_resp_rdata(d_resp_rdata2),
      .mem_cs(mem_cs2), .mem_re(mem_re2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_data(mem_data2));

   // Memory devices: drive the bus while read-enabled, store on write strobe
   logic [DW-1:0] mem  [0:(1<<AW)-1];
   logic [DW-1:0] mem2 [0:255];
   assign mem_data  = (mem_cs && mem_re) ? mem[mem_addr] : 'z;
   assign mem_data2 = (mem_cs2 && mem_re2) ? mem2[mem_addr2[7:0]] : 'z;
   always @(posedge clk) begin
      if (mem_cs && mem_wr) mem[mem_addr] <= mem_data;
      if (mem_cs2 && mem_wr2) mem2[mem_addr2[7:0]] <= mem_data2;
   end

   // Views of whichever instance a directed transaction targets
   int sel = 0;
   wire          v_ird  = sel ? i_req_ready2  : i_req_ready;
   wire          v_drd  = sel ? d_req_ready2  : d_req_ready;
   wire          v_iv   = sel ? i_resp_valid2 : i_resp_valid;
   wire          v_dv   = sel ? d_resp_valid2 : d_resp_valid;
   wire [DW-1:0] v_idat = sel ? i_resp_data2  : i_resp_data;
   wire [DW-1:0] v_ddat = sel ? d_resp_rdata2 : d_resp_rdata;
   wire          v_cs   = sel ? mem_cs2 : mem_cs;
   wire          v_re   = sel ? mem_re2 : mem_re;
   wire          v_wr   = sel ? mem_wr2 : mem_wr;
   wire [AW-1:0] v_addr = sel ? mem_addr2 : mem_addr;
   wire [DW-1:0] v_bus  = sel ? mem_data2 : mem_data;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input int which, input bit pd, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input bit v);
      if (which == 0) begin
         if (pd) begin d_req_valid = v; d_req_we = we; d_req_addr = a; d_req_wdata = wd; end
         else begin i_req_valid = v; i_req_addr = a; end
      end else begin
         if (pd) begin d_req_valid2 = v; d_req_we2 = we; d_req_addr2 = a; d_req_wdata2 = wd; end
         else begin i_req_valid2 = v; i_req_addr2 = a; end
      end
   endtask

   // One transaction from an idle controller: accept in cycle 0, busy 1..L, response in L+1
   task automatic txn(input int which, input bit pd, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] ex);
      int lat;
      lat = (which == 1) ? (we ? WL2 : RL2) : (we ? WL : RL);
      sel = which;
      @(negedge clk);
      drive(which, pd, we, a, wd, 1'b1);
      #1;
      chk("accept_ready", pd ? v_drd : v_ird, 1);
      chk("accept_other_ready", pd ? v_ird : v_drd, 0);
      chk("accept_no_resp", {v_iv, v_dv}, 0);
      for (int c = 1; c <= lat + 1; c++) begin
         @(negedge clk);
         if (c == 1) drive(which, pd, we, a, wd, 1'b0);
         #1;
         if (c <= lat) begin
            chk("busy_cs", v_cs, 1);
            chk("busy_re", v_re, !we);
            chk("busy_wr", v_wr, we);
            chk("busy_addr", v_addr, a);
            if (we) chk("busy_bus", v_bus, wd);
            chk("busy_no_resp", {v_iv, v_dv}, 0);
         end else begin
            chk("resp_valid", {v_iv, v_dv}, pd ? 2'b01 : 2'b10);
            chk("resp_cs_low", v_cs, 0);
            if (!we) chk("resp_data", pd ? v_ddat : v_idat, ex);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      i_req_valid = 0; d_req_valid = 0; i_req_valid2 = 0; d_req_valid2 = 0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_cs", mem_cs, 0);
      chk("rst_ready", {i_req_ready, d_req_ready}, 0);
      rst = 1'b0;
   endtask

   typedef struct {
      bit            pd;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vt[7];
   logic [DW-1:0] ref_mem [16];

   initial begin
      int got[4];
      int n, cyc;
      bit i_pend, d_pend, d_w, gi, gd, resp_d, resp_we, last_d, cs_exp;
      logic [AW-1:0] i_a, d_a;
      logic [DW-1:0] d_wd, resp_data;
      int next_free, resp_cyc, busy_lo, busy_hi, lat;

      vt[0] = '{1, 1, 20'h00010, 8'hA5, 8'h00};
      vt[1] = '{1, 0, 20'h00010, 8'h00, 8'hA5};
      vt[2] = '{0, 0, 20'hFFFFF, 8'h00, 8'h3C};
      vt[3] = '{1, 1, 20'hFFFFF, 8'h5A, 8'h00};
      vt[4] = '{0, 0, 20'hFFFFF, 8'h00, 8'h5A};
      vt[5] = '{1, 0, 20'h00000, 8'h00, 8'h11};
      vt[6] = '{0, 0, 20'h00010, 8'h00, 8'hA5};

      mem[20'h00000] = 8'h11;
      mem[20'hFFFFF] = 8'h3C;
      mem[20'h00020] = 8'hC3;
      mem[20'h00030] = 8'h96;
      for (int i = 0; i < 16; i++) begin
         mem[20'h100 + i] = 8'(i * 37 + 5);
         ref_mem[i]       = 8'(i * 37 + 5);
      end
      mem2[9] = 8'h42;

      // Reset state
      @(negedge clk);
      #1;
      chk("reset_strobes", {mem_cs, mem_re, mem_wr}, 0);
      chk("reset_ready", {i_req_ready, d_req_ready}, 0);
      chk("reset_resp", {i_resp_valid, d_resp_valid}, 0);
      chk("reset_i_data", i_resp_data, 0);
      chk("reset_d_data", d_resp_rdata, 0);
      chk("reset2_strobes", {mem_cs2, mem_re2, mem_wr2}, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 7; k++) txn(0, vt[k].pd, vt[k].we, vt[k].addr, vt[k].wdata, vt[k].exp);
      @(negedge clk);
      #1;
      chk("hold_d_data", d_resp_rdata, 8'h11);
      chk("hold_i_data", i_resp_data, 8'hA5);

      // Minimum latencies
      txn(1, 1, 1, 20'h5, 8'h77, 8'h00);
      txn(1, 1, 0, 20'h5, 8'h00, 8'h77);
      txn(1, 0, 0, 20'h9, 8'h00, 8'h42);
      sel = 0;

      // Simultaneous requests: D first, I accepted right after D's response
      do_reset();
      @(negedge clk);
      d_req_valid = 1; d_req_we = 0; d_req_addr = 20'h30;
      i_req_valid = 1; i_req_addr = 20'h20;
      #1;
      chk("tie_d_ready", d_req_ready, 1);
      chk("tie_i_ready", i_req_ready, 0);
      for (int c = 1; c <= RL + 1; c++) begin
         @(negedge clk);
         d_req_valid = 0;
         #1;
         chk("tie_i_waits", i_req_ready, 0);
         if (c == RL + 1) begin
            chk("tie_d_resp", d_resp_valid, 1);
            chk("tie_d_data", d_resp_rdata, 8'h96);
         end
      end
      @(negedge clk);
      #1;
      chk("tie_i_ready_after", i_req_ready, 1);
      for (int c = 1; c <= RL + 1; c++) begin
         @(negedge clk);
         i_req_valid = 0;
         #1;
         if (c == RL + 1) begin
            chk("tie_i_resp", {i_resp_valid, d_resp_valid}, 2'b10);
            chk("tie_i_data", i_resp_data, 8'hC3);
         end
      end

      // Continuous tie for four grants
      do_reset();
      @(negedge clk);
      d_req_valid = 1; d_req_we = 0; d_req_addr = 20'h30;
      i_req_valid = 1; i_req_addr = 20'h20;
      n = 0; cyc = 0;
      while (n < 4 && cyc < 100) begin
         #1;
         if (d_req_ready || i_req_ready) begin
            chk("rr_onehot", d_req_ready && i_req_ready, 0);
            got[n] = d_req_ready ? 1 : 0;
            n++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("rr_grant_count", n, 4);
      for (int k = 0; k < n; k++) begin
`ifdef ROUND_ROBIN_EN
         chk("rr_order", got[k], (k % 2 == 0) ? 1 : 0);
`else
         chk("fixed_order", got[k], 1);
`endif
      end
      i_req_valid = 0; d_req_valid = 0;
      repeat (RL + 3) @(negedge clk);

      // Reset in the middle of a read drops it
      @(negedge clk);
      d_req_valid = 1; d_req_we = 0; d_req_addr = 20'h30;
      #1;
      chk("mid_accept", d_req_ready, 1);
      repeat (4) @(negedge clk);
      d_req_valid = 0;
      #1;
      chk("mid_busy", {mem_cs, mem_re}, 2'b11);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_rst_strobes", {mem_cs, mem_re, mem_wr}, 0);
      chk("mid_rst_resp", {i_resp_valid, d_resp_valid}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < RL + 3; c++) begin
         @(negedge clk);
         #1;
         chk("mid_no_resp", {i_resp_valid, d_resp_valid, mem_cs}, 0);
      end
      txn(0, 0, 0, 20'h20, 8'h00, 8'hC3);

      // Random traffic against a transaction-level model
      do_reset();
      i_pend = 0; d_pend = 0; last_d = 0;
      i_a = '0; d_a = '0; d_w = 0; d_wd = '0;
      resp_d = 0; resp_we = 0; resp_data = '0;
      next_free = 0; resp_cyc = -1; busy_lo = -1; busy_hi = -2;
      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         if (!i_pend && $urandom_range(2) == 0) begin
            i_pend = 1; i_a = 20'h100 | AW'($urandom_range(15));
         end
         if (!d_pend && $urandom_range(2) == 0) begin
            d_pend = 1; d_w = 1'($urandom_range(1));
            d_a = 20'h100 | AW'($urandom_range(15)); d_wd = 8'($urandom);
         end
         i_req_valid = i_pend; i_req_addr = i_a;
         d_req_valid = d_pend; d_req_we = d_w; d_req_addr = d_a; d_req_wdata = d_wd;
         #1;
         gi = 0; gd = 0;
         if (t >= next_free) begin
            if (d_pend && i_pend) begin
`ifdef ROUND_ROBIN_EN
               if (last_d) gi = 1; else gd = 1;
`else
               gd = 1;
`endif
            end else begin
               gd = d_pend; gi = i_pend;
            end
         end
         cs_exp = (t >= busy_lo) && (t <= busy_hi);
         chk("rnd_ready", {i_req_ready, d_req_ready}, {gi, gd});
         chk("rnd_strobes", {mem_cs, mem_re, mem_wr}, {cs_exp, cs_exp && !resp_we, cs_exp && resp_we});
         if (t == resp_cyc) begin
            chk("rnd_resp", {i_resp_valid, d_resp_valid}, resp_d ? 2'b01 : 2'b10);
            if (!resp_we) chk("rnd_data", resp_d ? d_resp_rdata : i_resp_data, resp_data);
         end else begin
            chk("rnd_no_resp", {i_resp_valid, d_resp_valid}, 0);
         end
         if (gi || gd) begin
            resp_we = gd && d_w;
            resp_d  = gd;
            lat     = resp_we ? WL : RL;
            if (resp_we) ref_mem[d_a[3:0]] = d_wd;
            else resp_data = ref_mem[gd ? d_a[3:0] : i_a[3:0]];
            resp_cyc  = t + lat + 1;
            busy_lo   = t + 1;
            busy_hi   = t + lat;
            next_free = t + lat + 2;
            last_d    = gd;
            if (gd) d_pend = 0; else i_pend = 0;
         end
      end
      i_req_valid = 0; d_req_valid = 0;
      repeat (RL + 3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
